// File: rtl/fetch_ctrl_if.sv
// Fetch-stage control bundle between the PC sequencer and the fetch/decode datapath.
// The sequencer takes the slave view; the datapath or bench takes the master view.
interface fetch_ctrl_if;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] pc_f_i;
  logic [31:0] pcPlus4_f_i;
  logic [31:0] pc_next_o;
  logic        freeze_o;
  logic        flush_o;
  logic        valid_o;
  logic        trap_o;
  logic [15:0] redirect_count_o;

  modport slave (
    input  stall_i, redirect_i, redirect_pc_i, pc_f_i, pcPlus4_f_i,
    output pc_next_o, freeze_o, flush_o, valid_o, trap_o, redirect_count_o
  );

  modport master (
    output stall_i, redirect_i, redirect_pc_i, pc_f_i, pcPlus4_f_i,
    input  pc_next_o, freeze_o, flush_o, valid_o, trap_o, redirect_count_o
  );
endinterface

// File: rtl/fetch_ctrl.sv
// PC sequencer and hazard controller for the fetch stage: boot vectoring, stalls,
// redirects with a bubble window, misaligned-target trapping and a redirect counter.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FLUSH,
    TRAP
  } state_e;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  bubble_q, bubble_d;
  logic [15:0] count_q, count_d;

  logic        misaligned;
  logic [31:0] pc_next;
  logic        freeze;
  logic        flush;
  logic        valid;
  logic        trap;

  assign misaligned = bus.redirect_i && (bus.redirect_pc_i[1:0] != 2'b00);

  always_comb begin
    state_d  = state_q;
    bubble_d = bubble_q;
    count_d  = count_q;
    pc_next  = RESET_PC;
    freeze   = 1'b0;
    flush    = 1'b0;
    valid    = 1'b0;
    trap     = 1'b0;

    case (state_q)
      BOOT: begin
        state_d = RUN;
      end

      RUN, FLUSH: begin
        if (misaligned) begin
          // Hold fetch in the detecting cycle so the bad target never reaches it.
          pc_next = bus.pc_f_i;
          freeze  = 1'b1;
          flush   = 1'b1;
          state_d = TRAP;
        end else begin
          pc_next = bus.redirect_i ? bus.redirect_pc_i : bus.pcPlus4_f_i;
          freeze  = bus.stall_i && !bus.redirect_i;
          flush   = bus.redirect_i || (state_q == FLUSH);
          valid   = !flush;
          if (bus.redirect_i) begin
            count_d = count_q + 16'd1;
            if (FLUSH_LOAD != 4'd0) begin
              bubble_d = FLUSH_LOAD;
              state_d  = FLUSH;
            end else begin
              state_d  = RUN;
            end
          end else if ((state_q == FLUSH) && !freeze) begin
            bubble_d = bubble_q - 4'd1;
            if (bubble_q <= 4'd1) begin
              bubble_d = '0;
              state_d  = RUN;
            end
          end
        end
      end

      TRAP: begin
        pc_next = bus.pc_f_i;
        freeze  = 1'b1;
        flush   = 1'b1;
        trap    = 1'b1;
      end

      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= BOOT;
      bubble_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      bubble_q <= bubble_d;
      count_q  <= count_d;
    end
  end

  assign bus.pc_next_o        = pc_next;
  assign bus.freeze_o         = freeze;
  assign bus.flush_o          = flush;
  assign bus.valid_o          = valid;
  assign bus.trap_o           = trap;
  assign bus.redirect_count_o = count_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: two instances (bubble window 2 and 0), each with an emulated
// fetch register, checked every cycle against a transaction-level model.
module tb_fetch_ctrl;

  localparam logic [31:0] RPC_A = 32'h0000_0100;
  localparam logic [31:0] RPC_B = 32'h0000_0000;
  localparam int          FC_A  = 2;
  localparam int          FC_B  = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  fetch_ctrl_if bus_a ();
  fetch_ctrl_if bus_b ();

  fetch_ctrl #(.RESET_PC(RPC_A), .FLUSH_CYCLES(FC_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  fetch_ctrl #(.RESET_PC(RPC_B), .FLUSH_CYCLES(FC_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

  logic        stall [2] = '{1'b0, 1'b0};
  logic        redir [2] = '{1'b0, 1'b0};
  logic [31:0] rpc   [2] = '{32'h0, 32'h0};
  logic [31:0] pc_f  [2] = '{32'h0, 32'h0};

  logic [31:0] o_pc  [2];
  logic        o_frz [2];
  logic        o_fl  [2];
  logic        o_val [2];
  logic        o_trap[2];
  logic [15:0] o_cnt [2];

  assign bus_a.stall_i       = stall[0];
  assign bus_a.redirect_i    = redir[0];
  assign bus_a.redirect_pc_i = rpc[0];
  assign bus_a.pc_f_i        = pc_f[0];
  assign bus_a.pcPlus4_f_i   = pc_f[0] + 32'd4;
  assign bus_b.stall_i       = stall[1];
  assign bus_b.redirect_i    = redir[1];
  assign bus_b.redirect_pc_i = rpc[1];
  assign bus_b.pc_f_i        = pc_f[1];
  assign bus_b.pcPlus4_f_i   = pc_f[1] + 32'd4;

  assign o_pc[0]   = bus_a.pc_next_o;
  assign o_frz[0]  = bus_a.freeze_o;
  assign o_fl[0]   = bus_a.flush_o;
  assign o_val[0]  = bus_a.valid_o;
  assign o_trap[0] = bus_a.trap_o;
  assign o_cnt[0]  = bus_a.redirect_count_o;
  assign o_pc[1]   = bus_b.pc_next_o;
  assign o_frz[1]  = bus_b.freeze_o;
  assign o_fl[1]   = bus_b.flush_o;
  assign o_val[1]  = bus_b.valid_o;
  assign o_trap[1] = bus_b.trap_o;
  assign o_cnt[1]  = bus_b.redirect_count_o;

  // Fetch register emulation: loads pc_next unless frozen.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_f[0] <= 32'h0;
      pc_f[1] <= 32'h0;
    end else begin
      if (!o_frz[0]) pc_f[0] <= o_pc[0];
      if (!o_frz[1]) pc_f[1] <= o_pc[1];
    end
  end

  // Model state: booting, trapped, bubbles still owed, redirect count, fetch PC.
  bit          m_boot[2] = '{1'b1, 1'b1};
  bit          m_trap[2] = '{1'b0, 1'b0};
  int          m_bub [2] = '{0, 0};
  int          m_cnt [2] = '{0, 0};
  logic [31:0] m_pc  [2] = '{32'h0, 32'h0};

  function automatic logic [31:0] reset_pc_of(input int i);
    return (i == 0) ? RPC_A : RPC_B;
  endfunction

  function automatic int flush_of(input int i);
    return (i == 0) ? FC_A : FC_B;
  endfunction

  function automatic void model_out(input int i, output logic [31:0] pc,
                                    output logic frz, output logic fl,
                                    output logic val, output logic tr);
    pc = 32'h0; frz = 1'b0; fl = 1'b0; val = 1'b0; tr = 1'b0;
    if (m_boot[i]) begin
      pc = reset_pc_of(i);
    end else if (m_trap[i] || (redir[i] && (rpc[i] % 4 != 0))) begin
      pc = m_pc[i]; frz = 1'b1; fl = 1'b1; tr = m_trap[i];
    end else begin
      pc  = redir[i] ? rpc[i] : m_pc[i] + 32'd4;
      frz = stall[i] && !redir[i];
      fl  = redir[i] || (m_bub[i] > 0);
      val = !fl;
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_boot[i] = 1'b1; m_trap[i] = 1'b0; m_bub[i] = 0; m_cnt[i] = 0; m_pc[i] = 32'h0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        logic [31:0] pc;
        logic frz, fl, val, tr;
        model_out(i, pc, frz, fl, val, tr);
        if (m_boot[i]) begin
          m_boot[i] = 1'b0;
          m_pc[i]   = reset_pc_of(i);
        end else if (!m_trap[i]) begin
          if (redir[i] && (rpc[i] % 4 != 0)) begin
            m_trap[i] = 1'b1;
          end else begin
            if (!frz) m_pc[i] = pc;
            if (redir[i]) begin
              m_cnt[i] = (m_cnt[i] + 1) % 65536;
              m_bub[i] = flush_of(i);
            end else if (m_bub[i] > 0 && !stall[i]) begin
              m_bub[i] = m_bub[i] - 1;
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int inst, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d t=%0t got=%h expected=%h", name, inst, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [31:0] pc;
      logic frz, fl, val, tr;
      model_out(i, pc, frz, fl, val, tr);
      chk("m_pc_next", i, o_pc[i], pc);
      chk("m_freeze",  i, 32'(o_frz[i]), 32'(frz));
      chk("m_flush",   i, 32'(o_fl[i]), 32'(fl));
      chk("m_valid",   i, 32'(o_val[i]), 32'(val));
      chk("m_trap",    i, 32'(o_trap[i]), 32'(tr));
      chk("m_count",   i, 32'(o_cnt[i]), 32'(m_cnt[i]));
      chk("m_pc_f",    i, pc_f[i], m_pc[i]);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
    chk(name, 0, got, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t got=timeout expected=finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    // BOOT cycle
    neg(); lit("boot_pc_next", o_pc[0], 32'h100); lit("boot_valid", 32'(o_val[0]), 32'h0);
    lit("boot_count", 32'(o_cnt[0]), 32'h0);
    cyc(); neg(); lit("pc_100", pc_f[0], 32'h100); lit("valid_first", 32'(o_val[0]), 32'h1);
    cyc(); neg(); lit("pc_104", pc_f[0], 32'h104);
    // Three-cycle stall at 0x108
    cyc(); stall[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      neg(); lit("stall_pc", pc_f[0], 32'h108); lit("stall_freeze", 32'(o_frz[0]), 32'h1);
      cyc();
    end
    stall[0] = 1'b0;
    neg(); lit("unstall_pc", pc_f[0], 32'h108); lit("unstall_freeze", 32'(o_frz[0]), 32'h0);
    cyc(); neg(); lit("pc_10c", pc_f[0], 32'h10C);
    // Redirect to 0x200 at 0x110
    cyc(); redir[0] = 1'b1; rpc[0] = 32'h200;
    neg(); lit("redir_pc", pc_f[0], 32'h110); lit("redir_next", o_pc[0], 32'h200);
    lit("redir_flush", 32'(o_fl[0]), 32'h1);
    cyc(); redir[0] = 1'b0;
    neg(); lit("tgt_pc", pc_f[0], 32'h200); lit("tgt_flush", 32'(o_fl[0]), 32'h1);
    lit("count_1", 32'(o_cnt[0]), 32'h1);
    cyc(); neg(); lit("bubble2_flush", 32'(o_fl[0]), 32'h1);
    cyc(); neg(); lit("resume_pc", pc_f[0], 32'h208); lit("resume_valid", 32'(o_val[0]), 32'h1);
    // Redirect with stall, then stall during FLUSH
    cyc(); redir[0] = 1'b1; rpc[0] = 32'h300; stall[0] = 1'b1;
    neg(); lit("rs_freeze", 32'(o_frz[0]), 32'h0); lit("rs_next", o_pc[0], 32'h300);
    cyc(); redir[0] = 1'b0;
    neg(); lit("fs_pc", pc_f[0], 32'h300); lit("fs_freeze", 32'(o_frz[0]), 32'h1);
    cyc(); neg(); lit("fs_pc2", pc_f[0], 32'h300);
    cyc(); stall[0] = 1'b0;
    neg(); lit("fs_flush", 32'(o_fl[0]), 32'h1);
    cyc(); neg(); lit("fs_pc3", pc_f[0], 32'h304); lit("fs_flush2", 32'(o_fl[0]), 32'h1);
    cyc(); neg(); lit("fs_valid", 32'(o_val[0]), 32'h1); lit("count_2", 32'(o_cnt[0]), 32'h2);
    // Redirect inside FLUSH reloads the window
    cyc(); redir[0] = 1'b1; rpc[0] = 32'h400;
    cyc(); rpc[0] = 32'h500;
    cyc(); redir[0] = 1'b0;
    neg(); lit("reload_pc", pc_f[0], 32'h500);
    cyc(); cyc(); neg(); lit("reload_valid", 32'(o_val[0]), 32'h1);
    lit("reload_pc2", pc_f[0], 32'h508); lit("count_4", 32'(o_cnt[0]), 32'h4);
    // Misaligned redirect traps
    cyc(); redir[0] = 1'b1; rpc[0] = 32'h202;
    neg(); lit("mis_next", o_pc[0], 32'h50C); lit("mis_freeze", 32'(o_frz[0]), 32'h1);
    cyc(); rpc[0] = 32'h600;
    neg(); lit("trap_set", 32'(o_trap[0]), 32'h1); lit("trap_pc", pc_f[0], 32'h50C);
    cyc(); neg(); lit("trap_count", 32'(o_cnt[0]), 32'h4); lit("trap_hold", pc_f[0], 32'h50C);
    cyc(); redir[0] = 1'b0; rst_n = 1'b0;
    neg(); lit("rst_trap", 32'(o_trap[0]), 32'h0); lit("rst_next", o_pc[0], 32'h100);
    cyc(); rst_n = 1'b1;
    cyc(); neg(); lit("reboot_pc", pc_f[0], 32'h100);
    // Misaligned redirect during FLUSH
    cyc(); redir[0] = 1'b1; rpc[0] = 32'h700;
    cyc(); rpc[0] = 32'h701;
    cyc(); redir[0] = 1'b0;
    neg(); lit("ftrap_set", 32'(o_trap[0]), 32'h1); lit("ftrap_pc", pc_f[0], 32'h700);
    lit("ftrap_count", 32'(o_cnt[0]), 32'h1);
    cyc(); rst_n = 1'b0;
    cyc(); rst_n = 1'b1;
    repeat (3) cyc();
    // Counter wrap on the zero-bubble instance
    redir[1] = 1'b1; rpc[1] = 32'h1000;
    repeat (65535) cyc();
    neg(); chk("wrap_ffff", 1, 32'(o_cnt[1]), 32'h0000_FFFF);
    cyc(); redir[1] = 1'b0;
    neg(); chk("wrap_zero", 1, 32'(o_cnt[1]), 32'h0);
    chk("nobubble_valid", 1, 32'(o_val[1]), 32'h1);
    chk("nobubble_pc", 1, pc_f[1], 32'h1000);
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
